// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code parser: turns make/break byte sequences into held-key levels
// and first-press action pulses for the game control logic.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       ctrl_up,
  output logic       ctrl_down,
  output logic       ctrl_left,
  output logic       ctrl_right,
  output logic       shooting,
  output logic       enter,
  output logic       bomb
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_Z     = 4;
  localparam int K_ENTER = 5;
  localparam int K_X     = 6;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [6:0]      held_r;
  logic [6:0]      held_nxt_s;
  logic [6:0]      key_s;
  logic            ignore_s;
  logic            is_e0_s;
  logic            is_f0_s;
  logic            make_s;
  logic            brk_s;
  logic            ext_s;
  logic            enter_pulse_s;
  logic            bomb_pulse_s;

  // Classify the incoming byte: line-noise/controller bytes and the two prefixes.
  always_comb begin
    is_e0_s = (scan_code == 8'hE0);
    is_f0_s = (scan_code == 8'hF0);
    case (scan_code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ignore_s = scan_valid;
      default:                                  ignore_s = 1'b0;
    endcase
  end

  // A non-prefix byte completes the pending sequence as a make or a break.
  always_comb begin
    make_s = 1'b0;
    brk_s  = 1'b0;
    ext_s  = 1'b0;
    if (scan_valid && !ignore_s && !is_e0_s && !is_f0_s) begin
      case (state_r)
        IDLE:      make_s = 1'b1;
        EXT:       begin make_s = 1'b1; ext_s = 1'b1; end
        BREAK:     brk_s  = 1'b1;
        EXT_BREAK: begin brk_s = 1'b1; ext_s = 1'b1; end
        default:   make_s = 1'b0;
      endcase
    end else begin
      make_s = 1'b0;
    end
  end

  // Map the completed code to a key; arrows need E0, Enter must not have it.
  always_comb begin
    key_s = 7'b000_0000;
    case (scan_code)
      8'h75:   key_s[K_UP]    = ext_s;
      8'h72:   key_s[K_DOWN]  = ext_s;
      8'h6B:   key_s[K_LEFT]  = ext_s;
      8'h74:   key_s[K_RIGHT] = ext_s;
      8'h1A:   key_s[K_Z]     = 1'b1;
      8'h22:   key_s[K_X]     = 1'b1;
      8'h5A:   key_s[K_ENTER] = ~ext_s;
      default: key_s          = 7'b000_0000;
    endcase
  end

  // Next held-key state and first-press pulses (typematic repeats see the key already held).
  always_comb begin
    if (make_s) begin
      held_nxt_s = held_r | key_s;
    end else if (brk_s) begin
      held_nxt_s = held_r & ~key_s;
    end else begin
      held_nxt_s = held_r;
    end
    enter_pulse_s = make_s & key_s[K_ENTER] & ~held_r[K_ENTER];
    bomb_pulse_s  = make_s & key_s[K_X] & ~held_r[K_X];
  end

  // Parser FSM, stale-prefix timeout, held-key registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      to_cnt_r   <= '0;
      held_r     <= 7'b000_0000;
      ctrl_up    <= 1'b0;
      ctrl_down  <= 1'b0;
      ctrl_left  <= 1'b0;
      ctrl_right <= 1'b0;
      shooting   <= 1'b0;
      enter      <= 1'b0;
      bomb       <= 1'b0;
    end else begin
      held_r     <= held_nxt_s;
      ctrl_up    <= held_nxt_s[K_UP] & ~held_nxt_s[K_DOWN];
      ctrl_down  <= held_nxt_s[K_DOWN] & ~held_nxt_s[K_UP];
      ctrl_left  <= held_nxt_s[K_LEFT] & ~held_nxt_s[K_RIGHT];
      ctrl_right <= held_nxt_s[K_RIGHT] & ~held_nxt_s[K_LEFT];
      shooting   <= held_nxt_s[K_Z];
      enter      <= enter_pulse_s;
      bomb       <= bomb_pulse_s;

      if (scan_valid) begin
        to_cnt_r <= '0;
        if (ignore_s) begin
          state_r <= IDLE;
        end else begin
          case (state_r)
            IDLE:      state_r <= is_f0_s ? BREAK : (is_e0_s ? EXT : IDLE);
            EXT:       state_r <= is_f0_s ? EXT_BREAK : (is_e0_s ? EXT : IDLE);
            BREAK:     state_r <= is_e0_s ? EXT_BREAK : (is_f0_s ? BREAK : IDLE);
            EXT_BREAK: state_r <= (is_e0_s || is_f0_s) ? EXT_BREAK : IDLE;
            default:   state_r <= IDLE;
          endcase
        end
      end else if (state_r != IDLE) begin
        if (to_cnt_r == TO_LAST) begin
          state_r  <= IDLE;
          to_cnt_r <= '0;
        end else begin
          state_r  <= state_r;
          to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end else begin
        state_r  <= IDLE;
        to_cnt_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus queues expected output changes
// (cycle + vector); a negedge monitor pops one entry per observed output change.
module tb_ps2_key_decoder;

  localparam int TO = 100;
  // Output vector order: {up, down, left, right, shooting, enter, bomb}
  localparam logic [6:0] V0 = 7'b000_0000;
  localparam logic [6:0] UP = 7'b100_0000;
  localparam logic [6:0] DN = 7'b010_0000;
  localparam logic [6:0] LF = 7'b001_0000;
  localparam logic [6:0] RT = 7'b000_1000;
  localparam logic [6:0] SH = 7'b000_0100;
  localparam logic [6:0] EN = 7'b000_0010;
  localparam logic [6:0] BM = 7'b000_0001;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting, enter, bomb;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         last_cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         zero_req = 0;
  int         zero_seen = 0;
  bit         mon_en = 1'b0;
  bit         done = 1'b0;
  logic [6:0] prev_v = 7'b000_0000;
  logic [6:0] out_v;
  exp_t       e;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(7)) dut (
    .clk(clk), .rstn(rstn), .scan_code(scan_code), .scan_valid(scan_valid),
    .ctrl_up(ctrl_up), .ctrl_down(ctrl_down), .ctrl_left(ctrl_left),
    .ctrl_right(ctrl_right), .shooting(shooting), .enter(enter), .bomb(bomb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output change must match the next queued expectation exactly.
  always @(negedge clk) begin
    out_v = {ctrl_up, ctrl_down, ctrl_left, ctrl_right, shooting, enter, bomb};
    if (zero_req != zero_seen) begin
      zero_seen = zero_req;
      n_tests++;
      if (out_v !== V0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=%b", cyc, out_v, V0);
      end
    end
    if (!mon_en) begin
      prev_v = out_v;
    end else if (out_v !== prev_v) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, out_v, prev_v);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.vec !== out_v) begin
          n_fail++;
          $display("FAIL output_change cyc=%0d got=%b want cyc=%0d vec=%b",
                   cyc, out_v, e.cyc, e.vec);
        end
      end
      prev_v = out_v;
    end
    if (done) begin
      n_tests++;
      if (sb_q.size() != 0) begin
        n_fail++;
        $display("FAIL missing_changes got=%0d pending want=0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = b;
    last_cyc   = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      scan_valid = 1'b0;
      scan_code  = 8'h00;
    end
  endtask

  task automatic expect_at(input logic [6:0] v, input int offset);
    exp_t x;
    x.cyc = last_cyc + offset;
    x.vec = v;
    sb_q.push_back(x);
  endtask

  task automatic seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int len);
    send(a);
    if (len > 1) send(b);
    if (len > 2) send(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    #1 rstn = 1'b0;
    idle(2);
    zero_req++;
    idle(1);
    #1 rstn = 1'b1;
    idle(1);
    #1 mon_en = 1'b1;
  endtask

  initial begin
    idle(3);
    zero_req++;
    idle(1);
    #1 rstn = 1'b1;
    idle(1);
    #1 mon_en = 1'b1;

    // Reset in the middle of an E0 sequence clears held Z and the pending prefix
    send(8'h1A); expect_at(SH, 0); idle(2);
    send(8'hE0); idle(2);
    do_reset();
    send(8'h75); idle(3);

    // Arrow press/release, non-extended 75 ignored
    seq(8'hE0, 8'h75, 8'h00, 2); expect_at(UP, 0); idle(2);
    seq(8'hE0, 8'hF0, 8'h75, 3); expect_at(V0, 0); idle(2);
    send(8'h75); idle(3);

    // Enter typematic: one pulse per press
    send(8'h5A); expect_at(EN, 0); expect_at(V0, 1); idle(2);
    send(8'h5A); idle(1); send(8'h5A); send(8'h5A); idle(2);
    seq(8'hF0, 8'h5A, 8'h00, 2); idle(2);
    send(8'h5A); expect_at(EN, 0); expect_at(V0, 1); idle(2);
    seq(8'hF0, 8'h5A, 8'h00, 2); idle(2);
    // Keypad Enter never pulses
    seq(8'hE0, 8'h5A, 8'h00, 2); idle(2);
    seq(8'hE0, 8'hF0, 8'h5A, 3); idle(2);

    // X / bomb, with and without E0
    send(8'h22); expect_at(BM, 0); expect_at(V0, 1); idle(2);
    send(8'h22); send(8'h22); idle(2);
    seq(8'hF0, 8'h22, 8'h00, 2); idle(2);
    seq(8'hE0, 8'h22, 8'h00, 2); expect_at(BM, 0); expect_at(V0, 1); idle(2);
    seq(8'hF0, 8'h22, 8'h00, 2); idle(2);

    // Opposing directions cancel
    seq(8'hE0, 8'h75, 8'h00, 2); expect_at(UP, 0); idle(1);
    seq(8'hE0, 8'h72, 8'h00, 2); expect_at(V0, 0); idle(1);
    seq(8'hE0, 8'hF0, 8'h75, 3); expect_at(DN, 0); idle(1);
    seq(8'hE0, 8'hF0, 8'h72, 3); expect_at(V0, 0); idle(1);
    seq(8'hE0, 8'h6B, 8'h00, 2); expect_at(LF, 0); idle(1);
    seq(8'hE0, 8'h74, 8'h00, 2); expect_at(V0, 0); idle(1);
    seq(8'hE0, 8'hF0, 8'h74, 3); expect_at(LF, 0); idle(1);
    seq(8'hE0, 8'hF0, 8'h6B, 3); expect_at(V0, 0); idle(1);
    // Break of a key not held has no effect
    seq(8'hE0, 8'hF0, 8'h74, 3); idle(2);

    // Z held -> shooting until its break
    send(8'h1A); expect_at(SH, 0); idle(3);
    send(8'h1A); idle(3);
    seq(8'hF0, 8'h1A, 8'h00, 2); expect_at(V0, 0); idle(2);

    // Timeout: stale E0 dropped, 75 becomes an ignored non-extended make
    send(8'hE0); idle(TO + 5);
    send(8'h75); idle(3);
    // Just inside the window the prefix still applies
    send(8'hE0); idle(TO - 10);
    send(8'h75); expect_at(UP, 0); idle(2);
    seq(8'hE0, 8'hF0, 8'h75, 3); expect_at(V0, 0); idle(2);
    // Stale F0 dropped: the following 1A is a make, Z stays held
    send(8'h1A); expect_at(SH, 0); idle(1);
    send(8'hF0); idle(TO + 5);
    send(8'h1A); idle(3);
    seq(8'hF0, 8'h1A, 8'h00, 2); expect_at(V0, 0); idle(2);

    // Junk byte between F0 and the code drops the break
    seq(8'hE0, 8'h75, 8'h00, 2); expect_at(UP, 0); idle(1);
    seq(8'hF0, 8'hFA, 8'h75, 3); idle(3);
    seq(8'hE0, 8'hF0, 8'h75, 3); expect_at(V0, 0); idle(1);
    send(8'h1A); expect_at(SH, 0); idle(1);
    seq(8'hF0, 8'hFA, 8'h1A, 3); idle(3);
    seq(8'hF0, 8'h1A, 8'h00, 2); expect_at(V0, 0); idle(1);

    // Back-to-back strobes
    seq(8'hE0, 8'h74, 8'h00, 2); expect_at(RT, 0);
    seq(8'hE0, 8'hF0, 8'h74, 3); expect_at(V0, 0);
    send(8'h5A); expect_at(EN, 0); expect_at(V0, 1);
    send(8'hF0); send(8'h5A); send(8'h5A); expect_at(EN, 0); expect_at(V0, 1);
    idle(5);

    done = 1'b1;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
